serial_7seg_receiver: RTL

- Receive end of the 7-segment serial display link: deserializes the data/clock/latch stream produced by the display output serializer.
- Recovers the six 7-segment bytes and decoded BCD digits, plus decimal points.
- Used as an on-chip loopback checker and as the front end of a companion display-driver design.
- All serial inputs are treated as asynchronous; they are sampled and synchronized into i_clk.

---
 rtl/serial_7seg_receiver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_7seg_receiver.sv
// Receive end of the 7-segment serial display link: synchronizes the data/clock/latch
// stream into i_clk, deserializes 48-bit frames and decodes the six digits.
module serial_7seg_receiver #(
    parameter int FRAME_BITS  = 48,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_en,
    input  logic                  i_serial_data,
    input  logic                  i_serial_clk,
    input  logic                  i_serial_latch,
    output logic [FRAME_BITS-1:0] o_segments,
    output logic [3:0]            o_hours_msb,
    output logic [3:0]            o_hours_lsb,
    output logic [3:0]            o_minutes_msb,
    output logic [3:0]            o_minutes_lsb,
    output logic [3:0]            o_seconds_msb,
    output logic [3:0]            o_seconds_lsb,
    output logic [5:0]            o_dp,
    output logic                  o_frame_stb,
    output logic                  o_frame_err,
    output logic                  o_decode_err
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0] data_sync, clk_sync, latch_sync;
    logic                   clk_prev, latch_prev;
    logic [FRAME_BITS-1:0]  shift_reg, shift_next;
    logic [CNT_W-1:0]       bit_cnt, cnt_next;
    logic [5:0][3:0]        digit_q;
    logic [5:0][4:0]        dec;
    logic                   data_s, clk_s, latch_s;
    logic                   clk_rise, latch_rise, accept, any_dec_err;

    // Returns {illegal, digit}; blank (all segments off) is a legal 4'hF.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        unique case (seg)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h00:   decode = 5'h0F;
            default: decode = 5'h1F;
        endcase
    endfunction

    assign data_s     = data_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign clk_rise   = clk_s & ~clk_prev & i_en;
    assign latch_rise = latch_s & ~latch_prev & i_en;

    // A clock bit seen in the same cycle as the latch counts toward the latched frame.
    always_comb begin
        // NOTE: defaults first so every path assigns these and no latch is inferred.
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        if (clk_rise) begin
            shift_next = {shift_reg[FRAME_BITS-2:0], data_s};
            if (bit_cnt != CNT_MAX) cnt_next = bit_cnt + 1'b1;
        end
    end

    assign accept = latch_rise && (cnt_next == CNT_FRAME);

    always_comb begin
        any_dec_err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dec[i]      = decode(shift_next[8*i +: 7]);
            any_dec_err = any_dec_err | dec[i][4];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_sync    <= '0;
            clk_sync     <= '0;
            latch_sync   <= '0;
            clk_prev     <= 1'b0;
            latch_prev   <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            o_segments   <= '0;
            digit_q      <= {6{4'hF}};
            o_dp         <= '0;
            o_frame_stb  <= 1'b0;
            o_frame_err  <= 1'b0;
            o_decode_err <= 1'b0;
        end else begin
            data_sync   <= {data_sync[SYNC_STAGES-2:0], i_serial_data};
            clk_sync    <= {clk_sync[SYNC_STAGES-2:0], i_serial_clk};
            latch_sync  <= {latch_sync[SYNC_STAGES-2:0], i_serial_latch};
            clk_prev    <= clk_s;
            latch_prev  <= latch_s;
            shift_reg   <= shift_next;
            bit_cnt     <= latch_rise ? '0 : cnt_next;
            o_frame_stb <= accept;
            o_frame_err <= latch_rise && !accept;
            if (accept) begin
                o_segments   <= shift_next;
                o_decode_err <= any_dec_err;
                for (int i = 0; i < 6; i++) begin
                    digit_q[i] <= dec[i][3:0];
                    o_dp[i]    <= shift_next[8*i+7];
                end
            end
        end
    end

    assign o_hours_msb   = digit_q[5];
    assign o_hours_lsb   = digit_q[4];
    assign o_minutes_msb = digit_q[3];
    assign o_minutes_lsb = digit_q[2];
    assign o_seconds_msb = digit_q[1];
    assign o_seconds_lsb = digit_q[0];

endmodule
